// File: rtl/me_pkg.sv
// me_pkg: shared geometry, widths and FSM encoding for the motion-estimation pixel path.
package me_pkg;
  localparam int PIX_W     = 8;
  localparam int BEAT_PIX  = 8;
  localparam int CUR_ROWS  = 8;
  localparam int REF_ROWS  = 23;
  localparam int REF_PIX   = 23;
  localparam int REF_BEATS = (REF_PIX + BEAT_PIX - 1) / BEAT_PIX;
  localparam int CUR_W     = PIX_W * BEAT_PIX;
  localparam int REF_W     = PIX_W * REF_PIX;
  localparam int ROW_IDX_W = 5;
  typedef enum logic [1:0] {IDLE, CUR, REF, DONE} state_t;
endpackage

// File: rtl/me_row_feeder_if.sv
// me_row_feeder_if: beat input stream plus row-strobe outputs of the row feeder.
interface me_row_feeder_if;
  import me_pkg::*;
  logic [CUR_W-1:0]     in_data_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [CUR_W-1:0]     cur_data;
  logic                 cur_vld_o;
  logic [REF_W-1:0]     ref_data;
  logic                 ref_vld_o;
  logic [ROW_IDX_W-1:0] row_idx_o;
  logic                 busy_o;
  logic                 blk_done_o;
  modport master (
    output in_data_i, in_valid_i,
    input  in_ready_o, cur_data, cur_vld_o, ref_data, ref_vld_o, row_idx_o, busy_o, blk_done_o
  );
  modport slave (
    input  in_data_i, in_valid_i,
    output in_ready_o, cur_data, cur_vld_o, ref_data, ref_vld_o, row_idx_o, busy_o, blk_done_o
  );
endinterface

// File: rtl/me_row_assembler.sv
// me_row_assembler: packs three 64-bit beats into one 23-pixel search-window row.
module me_row_assembler
  import me_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CUR_W-1:0] beat,
  input  logic             accept,
  input  logic             clear,
  output logic             row_done,
  output logic [REF_W-1:0] row
);
  logic [1:0]         beat_cnt;
  logic [2*CUR_W-1:0] acc;
  logic               unused_pix;
  // the last beat is used straight off the bus so the row is ready on its accept edge
  assign row_done   = accept && beat_cnt == 2'(REF_BEATS - 1);
  assign row        = {beat[REF_W-2*CUR_W-1:0], acc};
  assign unused_pix = ^beat[CUR_W-1:REF_W-2*CUR_W];
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      beat_cnt <= '0;
      acc      <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      acc      <= '0;
    end else if (accept) begin
      beat_cnt <= row_done ? '0 : beat_cnt + 1'b1;
      acc      <= beat_cnt[0] ? {beat, acc[CUR_W-1:0]} : {acc[2*CUR_W-1:CUR_W], beat};
    end
  end
endmodule

// File: rtl/me_row_feeder.sv
// me_row_feeder: streams 8 current-block rows then 23 search-window rows per block to the me core.
module me_row_feeder
  import me_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          blk_start_i,
  input  logic          flush_i,
  me_row_feeder_if.slave bus
);
  state_t               state, state_nx;
  logic [ROW_IDX_W-1:0] row_cnt;
  logic                 acc_cur, acc_ref, row_done, last_cur, last_ref;
  logic [REF_W-1:0]     row;
  assign bus.in_ready_o = state == CUR || state == REF;
  assign bus.busy_o     = state != IDLE;
  assign bus.blk_done_o = state == DONE;
  // a flushed cycle accepts nothing, so no strobe can be queued behind it
  assign acc_cur  = bus.in_valid_i && state == CUR && !flush_i;
  assign acc_ref  = bus.in_valid_i && state == REF && !flush_i;
  assign last_cur = acc_cur && row_cnt == ROW_IDX_W'(CUR_ROWS - 1);
  assign last_ref = row_done && row_cnt == ROW_IDX_W'(REF_ROWS - 1);
  me_row_assembler u_asm (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .beat     (bus.in_data_i),
    .accept   (acc_ref),
    .clear    (flush_i),
    .row_done (row_done),
    .row      (row)
  );
  always_comb begin
    state_nx = flush_i ? IDLE :
               state == IDLE ? (blk_start_i ? CUR : IDLE) :
               state == CUR  ? (last_cur ? REF : CUR) :
               state == REF  ? (last_ref ? DONE : REF) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      row_cnt       <= '0;
      bus.cur_data  <= '0;
      bus.ref_data  <= '0;
      bus.cur_vld_o <= 1'b0;
      bus.ref_vld_o <= 1'b0;
      bus.row_idx_o <= '0;
    end else begin
      state         <= state_nx;
      row_cnt       <= (flush_i || last_cur || last_ref) ? '0 :
                       (acc_cur || row_done) ? row_cnt + 1'b1 : row_cnt;
      bus.cur_vld_o <= acc_cur;
      bus.ref_vld_o <= row_done;
      bus.row_idx_o <= (acc_cur || row_done) ? row_cnt : '0;
      if (acc_cur) bus.cur_data <= bus.in_data_i;
      if (row_done) bus.ref_data <= row;
    end
  end
endmodule

// File: tb/tb_me_row_feeder.sv
// tb_me_row_feeder: directed scenario tests for the motion-estimation row feeder.
module tb_me_row_feeder;
  import me_pkg::*;
  logic clk_i = 1'b0, rst_i = 1'b0, blk_start_i = 1'b0, flush_i = 1'b0;
  int n_cmp = 0, n_bad = 0;
  logic [4:0]   cur_idx_q[$];
  logic [63:0]  cur_dat_q[$];
  logic [4:0]   ref_idx_q[$];
  logic [183:0] ref_dat_q[$];
  int done_cnt = 0, done_ok = 0, excl_err = 0, idx_err = 0, orphan_err = 0;
  logic acc_seen = 1'b0;
  localparam logic [183:0] PACK_ROW =
    184'h16151413121110_0F0E0D0C0B0A0908_0706050403020100;

  me_row_feeder_if bus();
  me_row_feeder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .blk_start_i (blk_start_i),
    .flush_i     (flush_i),
    .bus         (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if ((bus.cur_vld_o || bus.ref_vld_o) && !acc_seen) orphan_err++;
    if (bus.cur_vld_o && bus.ref_vld_o) excl_err++;
    if (!bus.cur_vld_o && !bus.ref_vld_o && bus.row_idx_o != 5'd0) idx_err++;
    if (bus.cur_vld_o) begin
      cur_idx_q.push_back(bus.row_idx_o);
      cur_dat_q.push_back(bus.cur_data);
    end
    if (bus.ref_vld_o) begin
      ref_idx_q.push_back(bus.row_idx_o);
      ref_dat_q.push_back(bus.ref_data);
    end
    if (bus.blk_done_o) begin
      done_cnt++;
      if (bus.ref_vld_o && bus.row_idx_o == 5'd22) done_ok++;
    end
    acc_seen = bus.in_valid_i && bus.in_ready_o && !flush_i && rst_i;
  end

  function automatic logic [183:0] exp_ref(input int r);
    logic [7:0] b0, b1, b2;
    b0 = 8'(8 + 3 * r);
    b1 = 8'(9 + 3 * r);
    b2 = 8'(10 + 3 * r);
    return {{7{b2}}, {8{b1}}, {8{b0}}};
  endfunction

  function automatic int block_errs(input int cb, input int rb);
    int e = 0;
    if (cur_idx_q.size() < cb + 8 || ref_idx_q.size() < rb + 23) return 999;
    for (int k = 0; k < 8; k++)
      if (cur_idx_q[cb+k] !== 5'(k) || cur_dat_q[cb+k] !== {8{8'(k)}}) e++;
    for (int r = 0; r < 23; r++)
      if (ref_idx_q[rb+r] !== 5'(r) || ref_dat_q[rb+r] !== exp_ref(r)) e++;
    return e;
  endfunction

  task automatic feed(input int nbeats, input bit start, input bit stall, input int extra_at,
                      output int got);
    bit acc, pulsed = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 2000 && got < nbeats; cyc++) begin
      bus.in_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data_i  = {8{8'(got)}};
      blk_start_i    = (start && cyc == 0) || (!pulsed && got == extra_at);
      if (got == extra_at) pulsed = 1'b1;
      acc = bus.in_valid_i && bus.in_ready_o;
      @(posedge clk_i); #1;
      if (acc) got++;
    end
    bus.in_valid_i = 1'b0;
    blk_start_i    = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    #12;
    n_cmp++; if (bus.cur_vld_o !== 1'b0 || bus.ref_vld_o !== 1'b0) begin n_bad++; $display("FAIL reset_vld cur=%b ref=%b want 0 0", bus.cur_vld_o, bus.ref_vld_o); end
    n_cmp++; if (bus.cur_data !== 64'd0 || bus.ref_data !== 184'd0) begin n_bad++; $display("FAIL reset_data cur=%h ref=%h want 0", bus.cur_data, bus.ref_data); end
    n_cmp++; if ({bus.in_ready_o, bus.busy_o, bus.blk_done_o, bus.row_idx_o} !== 8'd0) begin n_bad++; $display("FAIL reset_ctl rdy=%b busy=%b done=%b idx=%0d want all 0", bus.in_ready_o, bus.busy_o, bus.blk_done_o, bus.row_idx_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i); #1;
  endtask

  task automatic test_latency;
    blk_start_i = 1'b1; bus.in_valid_i = 1'b1; bus.in_data_i = '0;
    @(posedge clk_i); #1;
    blk_start_i = 1'b0;
    n_cmp++; if (bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.cur_vld_o !== 1'b0) begin n_bad++; $display("FAIL lat_cyc1 rdy=%b busy=%b vld=%b want 1 1 0", bus.in_ready_o, bus.busy_o, bus.cur_vld_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (bus.cur_vld_o !== 1'b1 || bus.row_idx_o !== 5'd0 || bus.cur_data !== 64'd0) begin n_bad++; $display("FAIL lat_cyc2 vld=%b idx=%0d data=%h want 1 0 0", bus.cur_vld_o, bus.row_idx_o, bus.cur_data); end
    flush_i = 1'b1; bus.in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL lat_flush busy=%b want 0", bus.busy_o); end
    repeat (2) @(posedge clk_i); #1;
  endtask

  task automatic test_basic(input bit stall, input string tag);
    int cb = cur_idx_q.size(), rb = ref_idx_q.size(), d0 = done_cnt, k0 = done_ok;
    int x0 = excl_err, i0 = idx_err, o0 = orphan_err, got, e;
    feed(77, 1'b1, stall, -1, got);
    repeat (3) @(posedge clk_i); #1;
    n_cmp++; if (got !== 77) begin n_bad++; $display("FAIL %s_beats accepted=%0d want 77", tag, got); end
    n_cmp++; if (cur_idx_q.size() - cb + ref_idx_q.size() - rb !== 31) begin n_bad++; $display("FAIL %s_strobes got=%0d want 31", tag, cur_idx_q.size() - cb + ref_idx_q.size() - rb); end
    e = block_errs(cb, rb);
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL %s_rows bad_rows=%0d want 0", tag, e); end
    n_cmp++; if (done_cnt - d0 !== 1 || done_ok - k0 !== 1) begin n_bad++; $display("FAIL %s_done pulses=%0d coincident=%0d want 1 1", tag, done_cnt - d0, done_ok - k0); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL %s_busy busy=%b want 0", tag, bus.busy_o); end
    n_cmp++; if (excl_err - x0 + idx_err - i0 + orphan_err - o0 !== 0) begin n_bad++; $display("FAIL %s_proto excl=%0d idx=%0d orphan=%0d want 0", tag, excl_err - x0, idx_err - i0, orphan_err - o0); end
  endtask

  task automatic test_packing;
    logic [63:0] pb[3];
    int got;
    pb[0] = 64'h0706050403020100; pb[1] = 64'h0F0E0D0C0B0A0908; pb[2] = 64'h1716151413121110;
    feed(8, 1'b1, 1'b0, -1, got);
    for (int b = 0; b < 3; b++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = pb[b];
      @(posedge clk_i); #1;
    end
    bus.in_valid_i = 1'b0;
    n_cmp++; if (bus.ref_vld_o !== 1'b1 || bus.row_idx_o !== 5'd0) begin n_bad++; $display("FAIL pack_strobe vld=%b idx=%0d want 1 0", bus.ref_vld_o, bus.row_idx_o); end
    n_cmp++; if (bus.ref_data[183:176] !== 8'h16 || bus.ref_data[7:0] !== 8'h00) begin n_bad++; $display("FAIL pack_ends top=%h bottom=%h want 16 00", bus.ref_data[183:176], bus.ref_data[7:0]); end
    n_cmp++; if (bus.ref_data !== PACK_ROW) begin n_bad++; $display("FAIL pack_row got=%h want %h", bus.ref_data, PACK_ROW); end
    for (int b = 0; b < 3; b++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
      flush_i = (b == 2);
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0; bus.in_valid_i = 1'b0;
    n_cmp++; if (bus.ref_vld_o !== 1'b0 || bus.in_ready_o !== 1'b0 || bus.blk_done_o !== 1'b0) begin n_bad++; $display("FAIL pack_flush vld=%b rdy=%b done=%b want 0 0 0", bus.ref_vld_o, bus.in_ready_o, bus.blk_done_o); end
    n_cmp++; if (bus.ref_data !== PACK_ROW) begin n_bad++; $display("FAIL pack_hold got=%h want %h", bus.ref_data, PACK_ROW); end
    repeat (2) @(posedge clk_i); #1;
  endtask

  task automatic test_ignored_start;
    int cb = cur_idx_q.size(), rb = ref_idx_q.size(), d0 = done_cnt, got, e, cn, rn;
    feed(77, 1'b1, 1'b0, 8 + 15, got);
    repeat (3) @(posedge clk_i); #1;
    e = block_errs(cb, rb);
    n_cmp++; if (got !== 77 || e !== 0) begin n_bad++; $display("FAIL ign_rows accepted=%0d bad_rows=%0d want 77 0", got, e); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL ign_done pulses=%0d want 1", done_cnt - d0); end
    cn = cur_idx_q.size(); rn = ref_idx_q.size();
    bus.in_valid_i = 1'b1;
    repeat (6) @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    n_cmp++; if (cur_idx_q.size() !== cn || ref_idx_q.size() !== rn || bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL ign_idle new_strobes=%0d busy=%b rdy=%b want 0 0 0", cur_idx_q.size() - cn + ref_idx_q.size() - rn, bus.busy_o, bus.in_ready_o); end
  endtask

  task automatic test_flush;
    int rb = ref_idx_q.size(), d0 = done_cnt, got;
    feed(40, 1'b1, 1'b0, -1, got);
    flush_i = 1'b1; bus.in_valid_i = 1'b1; bus.in_data_i = {8{8'd40}};
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    n_cmp++; if (bus.in_ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_state rdy=%b busy=%b want 0 0", bus.in_ready_o, bus.busy_o); end
    repeat (5) @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    n_cmp++; if (ref_idx_q.size() - rb !== 10 || done_cnt - d0 !== 0) begin n_bad++; $display("FAIL flush_strobes ref_rows=%0d done=%0d want 10 0", ref_idx_q.size() - rb, done_cnt - d0); end
    test_basic(1'b0, "after_flush");
  endtask

  task automatic test_async_reset;
    int got;
    feed(4, 1'b1, 1'b0, -1, got);
    n_cmp++; if (bus.cur_vld_o !== 1'b1 || bus.row_idx_o !== 5'd3) begin n_bad++; $display("FAIL ares_pre vld=%b idx=%0d want 1 3", bus.cur_vld_o, bus.row_idx_o); end
    #2 rst_i = 1'b0;
    #1;
    n_cmp++; if ({bus.cur_vld_o, bus.ref_vld_o, bus.row_idx_o, bus.busy_o, bus.in_ready_o} !== 9'd0) begin n_bad++; $display("FAIL ares_ctl cvld=%b rvld=%b idx=%0d busy=%b rdy=%b want all 0", bus.cur_vld_o, bus.ref_vld_o, bus.row_idx_o, bus.busy_o, bus.in_ready_o); end
    n_cmp++; if (bus.cur_data !== 64'd0) begin n_bad++; $display("FAIL ares_data cur=%h want 0", bus.cur_data); end
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;
    test_basic(1'b0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_latency;
    test_basic(1'b0, "basic");
    test_packing;
    test_basic(1'b1, "stall");
    test_ignored_start;
    test_flush;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
